uart_sif2apb_bridge: RTL and testbench
======================================

// Module: uart_sif2apb_bridge
// PURPOSE
//  Bus-master bridge upstream of the UART's APB slave (uart_apb): converts single-cycle
//  simple-interface requests (addr/re/we/wd) from a CPU/test master into APB3 transfers.
//  Holds one request in flight plus one pending slot; handles pready wait states,
//  pslverr and an optional access timeout. Returns read data and status on rd/done/err.
// PARAMETERS
//  AW       32   address width (paddr, addr)
//  DW       32   data width (pwdata, prdata, wd, rd)
//  TIMEOUT  256  max ACCESS cycles with pready=0 before abort; 0 = no timeout
// PORTS
//  pclk     in   1   clock, single domain; all flops on rising edge
//  presetn  in   1   asynchronous active-low reset
//  addr     in   AW  request address
//  re       in   1   read request, sampled when busy=0
//  we       in   1   write request, sampled when busy=0; wins over re if both high
//  wd       in   DW  write data, sampled with we
//  rd       out  DW  read data, valid while done=1 for a read
//  done     out  1   one-cycle pulse: transfer finished
//  err      out  1   valid with done: pslverr=1 or timeout
//  busy     out  1   pending slot full; new requests ignored while high
//  paddr    out  AW  APB address
//  pwdata   out  DW  APB write data
//  pwrite   out  1   APB direction
//  psel     out  1   APB select
//  penable  out  1   APB enable
//  prdata   in   DW  APB read data
//  pready   in   1   APB ready
//  pslverr  in   1   APB error, sampled with pready
// BEHAVIOUR
//  Reset (async, presetn=0): all outputs 0, FSM=IDLE, pending slot empty, timeout counter 0.
//  Reset asserted mid-transfer aborts immediately; no done is produced for the aborted transfer.
//  FSM: IDLE -> SETUP -> ACCESS -> (IDLE | SETUP).
//  Request capture: (re|we) with busy=0 at edge N writes {addr,wd,we} into the pending slot.
//   Capture and launch can occur on the same edge.
//  IDLE:   if slot full (or being filled) -> load paddr/pwdata/pwrite, psel=1, penable=0,
//          free slot -> SETUP. A request at edge N gives psel=1 in cycle N+1.
//  SETUP:  one cycle, then penable=1 -> ACCESS. paddr/pwdata/pwrite stable SETUP..ACCESS end.
//  ACCESS: each edge with pready=1 completes the transfer.
//          Next cycle: done=1; err=pslverr; rd=prdata if read, else rd=0.
//          If slot full: -> SETUP back-to-back (psel stays 1, penable=0).
//          Otherwise: psel=0, penable=0 -> IDLE.
//          Zero-wait transfer: psel high 2 cycles; done in the cycle after ACCESS.
//  Timeout (TIMEOUT>0): counter +1 per ACCESS cycle with pready=0, cleared on entering SETUP.
//   When the counter reaches TIMEOUT: drop psel/penable, done=1, err=1, rd=0, -> IDLE/SETUP as above.
//   Exactly one of pready-completion or timeout occurs; pready on the same edge wins.
//  busy = slot full. A request while busy=1 is dropped silently (master must check busy).
//  paddr/pwdata/pwrite hold their last values in IDLE; psel=penable=0 there.
//  re=we=1 -> write. re/we of 0 never touch the slot.
//  done is never high two consecutive cycles for the same transfer; err=0 whenever done=0.
// TESTING
//  T1 write, pready=1 always: we addr=0x4 wd=0xA5
//     -> SETUP at N+1, ACCESS at N+2, pwdata=0xA5, pwrite=1, done=1 err=0 at N+3.
//  T2 read with 3 wait states, prdata=0x5A
//     -> penable high 4 cycles, addrs stable, done=1 rd=0x5A err=0.
//  T3 write with pslverr=1 on pready -> done=1 err=1; next request proceeds normally.
//  T4 two requests back-to-back (2nd while 1st in SETUP)
//     -> busy=1 until 2nd launches, ACCESS->SETUP without psel drop, two done pulses;
//        3rd request while busy is dropped.
//  T5 TIMEOUT=8, pready held 0 -> after 8 ACCESS cycles psel=0, done=1 err=1 rd=0.
//  T6 presetn pulled low during ACCESS -> all outputs 0 at once, no done, busy=0;
//     after release a fresh read completes OK.

Source files
------------

// File: rtl/uart_sif2apb_bridge.sv
// Simple-interface to APB3 master bridge: one transfer in flight plus one pending request slot.
// Latency: request at edge N -> psel in cycle N+1, done the cycle after pready; busy = slot full.
module uart_sif2apb_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic [AW-1:0] addr,
  input  logic          re,
  input  logic          we,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic          done,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  output logic          pwrite,
  output logic          psel,
  output logic          penable,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state_q, state_d;
  logic          slot_vld_q, slot_vld_d;
  logic [AW-1:0] slot_addr_q, slot_addr_d;
  logic [DW-1:0] slot_wd_q, slot_wd_d;
  logic          slot_we_q, slot_we_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] rd_q, rd_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic          capture;
  logic          have_next;
  logic          tmo_hit;
  logic [AW-1:0] next_addr;
  logic [DW-1:0] next_wd;
  logic          next_we;

  // A request arriving with the slot empty can bypass it and launch directly.
  assign capture   = (re | we) & ~slot_vld_q;
  assign have_next = slot_vld_q | capture;
  assign next_addr = slot_vld_q ? slot_addr_q : addr;
  assign next_wd   = slot_vld_q ? slot_wd_q   : wd;
  assign next_we   = slot_vld_q ? slot_we_q   : we;
  assign tmo_hit   = TMO_EN && !pready && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_wd_d   = slot_wd_q;
    slot_we_d   = slot_we_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_d        = '0;

    if (capture) begin
      slot_vld_d  = 1'b1;
      slot_addr_d = addr;
      slot_wd_d   = wd;
      slot_we_d   = we;
    end

    case (state_q)
      IDLE: begin
        if (have_next) begin
          paddr_d    = next_addr;
          pwdata_d   = next_wd;
          pwrite_d   = next_we;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          slot_vld_d = 1'b0;
          tmo_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready || tmo_hit) begin
          done_d = 1'b1;
          err_d  = pready ? pslverr : 1'b1;
          rd_d   = (pready && !pwrite_q) ? prdata : '0;
          if (have_next) begin
            paddr_d    = next_addr;
            pwdata_d   = next_wd;
            pwrite_d   = next_we;
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            slot_vld_d = 1'b0;
            tmo_d      = '0;
            state_d    = SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      slot_vld_q  <= 1'b0;
      slot_addr_q <= '0;
      slot_wd_q   <= '0;
      slot_we_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      slot_wd_q   <= slot_wd_d;
      slot_we_q   <= slot_we_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      tmo_q       <= tmo_d;
    end
  end

  assign rd      = rd_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = slot_vld_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign psel    = psel_q;
  assign penable = penable_q;

endmodule

// File: tb/tb_uart_sif2apb_bridge.sv
// Bench for uart_sif2apb_bridge: directed timing checks plus a scoreboard of expected done/err/rd.
module tb_uart_sif2apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 8;

  logic          pclk;
  logic          presetn;
  logic [AW-1:0] addr;
  logic          re;
  logic          we;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic          done;
  logic          err;
  logic          busy;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  uart_sif2apb_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn), .addr(addr), .re(re), .we(we), .wd(wd),
    .rd(rd), .done(done), .err(err), .busy(busy),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            exp_err;
    logic [DW-1:0] exp_rd;
  } txn_t;

  txn_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Slave behaviour knobs
  int            wait_cfg = 0;
  bit            err_cfg  = 0;
  logic [DW-1:0] data_cfg = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // APB slave: inserts wait_cfg wait states per ACCESS phase
  initial begin : slave
    int ws;
    ws = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (ws == wait_cfg) begin
          pready = 1'b1; pslverr = err_cfg; prdata = data_cfg;
        end else begin
          pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
        end
        ws++;
      end else begin
        pready = 1'b0; pslverr = 1'b0; ws = 0;
      end
    end
  end

  // Monitor: APB fields against scoreboard head, done/err/rd against popped expectation
  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (sb_q.size() == 0) check("apb_unexpected", 1, 0);
        else begin
          check("paddr", paddr, sb_q[0].a);
          check("pwrite", pwrite, sb_q[0].w);
          if (sb_q[0].w) check("pwdata", pwdata, sb_q[0].d);
        end
      end
      if (done) begin
        if (sb_q.size() == 0) check("extra_done", 1, 0);
        else begin
          t = sb_q.pop_front();
          check("done_err", err, t.exp_err);
          check("done_rd", rd, t.exp_rd);
        end
      end else if (err) begin
        check("err_without_done", err, 0);
      end
    end
  end

  // Drive one request for one edge; expectation pushed only if the bridge can accept it
  task automatic issue(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    bit   wr;
    wr = w;
    we = w; re = r; addr = a; wd = d;
    if (!busy) begin
      t.w = wr; t.a = a; t.d = d;
      if (wait_cfg >= TMO) begin
        t.exp_err = 1'b1; t.exp_rd = '0;
      end else begin
        t.exp_err = err_cfg; t.exp_rd = wr ? '0 : data_cfg;
      end
      sb_q.push_back(t);
    end
    @(negedge pclk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic xfer(input string tag, input bit w, input bit r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int exp_pen);
    int pen;
    int guard;
    issue(w, r, a, d);
    check({tag, "_setup_psel"}, psel, 1);
    check({tag, "_setup_pen"}, penable, 0);
    pen = 0; guard = 0;
    do begin
      @(negedge pclk);
      if (penable) pen++;
      guard++;
    end while (penable && guard < 60);
    check({tag, "_pen_cycles"}, pen, exp_pen);
    check({tag, "_done"}, done, 1);
    check({tag, "_psel_drop"}, psel, 0);
  endtask

  initial begin : stim
    int dn;
    int gaps;
    int guard;
    presetn = 1'b0; addr = '0; re = 1'b0; we = 1'b0; wd = '0;
    #1;
    check("rst_outputs", {rd, done, err, busy, paddr, pwdata, pwrite, psel, penable}, '0);
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // T1 zero-wait write
    wait_cfg = 0; err_cfg = 0;
    xfer("t1", 1'b1, 1'b0, 32'h4, 32'hA5, 1);

    // T2 read with three wait states
    wait_cfg = 3; data_cfg = 32'h5A;
    xfer("t2", 1'b0, 1'b1, 32'h8, 32'h0, 4);

    // T3 slave error on a write issued with re and we both high, then a clean read
    wait_cfg = 0; err_cfg = 1;
    xfer("t3_err", 1'b1, 1'b1, 32'hC, 32'h77, 1);
    err_cfg = 0; data_cfg = 32'h33;
    xfer("t3_next", 1'b0, 1'b1, 32'h10, 32'h0, 1);

    // T4 back-to-back: second request during SETUP, third dropped while busy
    wait_cfg = 2; data_cfg = 32'h1234_5678;
    issue(1'b1, 1'b0, 32'h20, 32'h11);
    issue(1'b0, 1'b1, 32'h24, 32'h0);
    check("t4_busy", busy, 1);
    issue(1'b1, 1'b0, 32'h28, 32'h99);
    dn = 0; gaps = 0; guard = 0;
    while (dn < 2 && guard < 40) begin
      if (done) begin
        dn++;
        if (dn == 1) check("t4_busy_cleared", busy, 0);
      end
      if (dn <= 1 && !psel) gaps++;
      if (dn < 2) @(negedge pclk);
      guard++;
    end
    check("t4_done_pulses", dn, 2);
    check("t4_psel_gaps", gaps, 0);
    repeat (6) @(negedge pclk);
    check("t4_dropped", sb_q.size(), 0);

    // T5 timeout after TMO ACCESS cycles
    wait_cfg = 1000;
    xfer("t5", 1'b0, 1'b1, 32'h30, 32'h0, TMO);

    // T6 reset mid-ACCESS
    issue(1'b0, 1'b1, 32'h40, 32'h0);
    repeat (3) @(negedge pclk);
    check("t6_in_access", penable, 1);
    presetn = 1'b0;
    #1;
    check("t6_rst_outputs", {rd, done, err, busy, paddr, pwdata, pwrite, psel, penable}, '0);
    sb_q.delete();
    repeat (2) @(negedge pclk);
    check("t6_no_done", done, 0);
    presetn = 1'b1;
    @(negedge pclk);
    wait_cfg = 1; data_cfg = 32'hC3;
    xfer("t6_after", 1'b0, 1'b1, 32'h44, 32'h0, 2);

    guard = 0;
    while (sb_q.size() != 0 && guard < 50) begin
      @(negedge pclk);
      guard++;
    end
    check("sb_drained", sb_q.size(), 0);
    repeat (3) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
